// File: rtl/pc_gen_unit_pkg.sv
// rtl/pc_gen_unit_pkg.sv - shared core constants, FSM encoding and redirect types for PC generation
package pc_gen_unit_pkg;

  localparam int          CORE_XLEN     = 32;
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCG_BOOT  = 2'd0,
    PCG_RUN   = 2'd1,
    PCG_FLUSH = 2'd2
  } pcg_state_e;

  // Control-transfer opcodes shared with branch_unit
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  typedef struct packed {
    logic                 valid;
    logic                 is_trap;
    logic [CORE_XLEN-1:0] target;
  } pcg_redirect_t;

  function automatic logic is_ctrl_opcode(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  // JALR clears bit 0 of the computed target
  function automatic logic [CORE_XLEN-1:0] jalr_align(input logic [CORE_XLEN-1:0] t);
    return {t[CORE_XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// rtl/pc_gen_unit_if.sv - redirect request and fetch-address bundle of the PC generation stage
interface pc_gen_unit_if
  import pc_gen_unit_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
);
  logic            branch_taken_in;
  logic [XLEN-1:0] target_addr_in;
  logic            trap_taken_in;
  logic [XLEN-1:0] trap_vec_in;
  logic            mret_in;
  logic [XLEN-1:0] epc_in;
  logic            stall_in;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_4_out;
  logic [XLEN-1:0] i_addr_out;
  logic            fetch_valid_out;
  logic            flush_out;
  logic            misaligned_instr_out;

  modport slave (
    input  branch_taken_in, target_addr_in, trap_taken_in, trap_vec_in,
    input  mret_in, epc_in, stall_in,
    output pc_out, pc_plus_4_out, i_addr_out, fetch_valid_out, flush_out,
    output misaligned_instr_out
  );

  modport master (
    output branch_taken_in, target_addr_in, trap_taken_in, trap_vec_in,
    output mret_in, epc_in, stall_in,
    input  pc_out, pc_plus_4_out, i_addr_out, fetch_valid_out, flush_out,
    input  misaligned_instr_out
  );
endinterface

// File: rtl/pc_gen_unit_pc_next_sel.sv
// rtl/pc_gen_unit_pc_next_sel.sv - combinational next-PC priority mux and redirect alignment check
module pc_next_sel
  import pc_gen_unit_pkg::*;
(
  input  logic [CORE_XLEN-1:0] pc_i,
  input  logic                 branch_taken_i,
  input  logic [CORE_XLEN-1:0] target_addr_i,
  input  logic                 trap_taken_i,
  input  logic [CORE_XLEN-1:0] trap_vec_i,
  input  logic                 mret_i,
  input  logic [CORE_XLEN-1:0] epc_i,
  input  pcg_redirect_t        pending_i,
  output logic                 misaligned_o,
  output logic                 run_redirect_o,
  output logic [CORE_XLEN-1:0] run_next_pc_o,
  output pcg_redirect_t        stall_req_o
);

  logic                 branch_ok;
  logic [CORE_XLEN-1:0] branch_tgt;
  logic                 pend_trap_locked;

  assign misaligned_o     = branch_taken_i & target_addr_i[1];
  assign branch_ok        = branch_taken_i & ~target_addr_i[1];
  assign branch_tgt       = jalr_align(target_addr_i);
  assign pend_trap_locked = pending_i.valid & pending_i.is_trap;

  always_comb begin
    run_redirect_o = 1'b1;
    run_next_pc_o  = pc_i + CORE_XLEN'(4);
    if (trap_taken_i) begin
      run_next_pc_o = trap_vec_i;
    end else if (pending_i.valid) begin
      run_next_pc_o = pending_i.target;
    end else if (mret_i) begin
      run_next_pc_o = epc_i;
    end else if (branch_ok) begin
      run_next_pc_o = branch_tgt;
    end else if (misaligned_o) begin
      // Fetch parks here until the trap unit reports the misalignment
      run_redirect_o = 1'b0;
      run_next_pc_o  = pc_i;
    end else begin
      run_redirect_o = 1'b0;
    end
  end

  // Value the pending register takes if this cycle is stalled
  always_comb begin
    stall_req_o = pending_i;
    if (trap_taken_i) begin
      stall_req_o = '{valid: 1'b1, is_trap: 1'b1, target: trap_vec_i};
    end else if (!pend_trap_locked && mret_i) begin
      stall_req_o = '{valid: 1'b1, is_trap: 1'b0, target: epc_i};
    end else if (!pend_trap_locked && branch_ok) begin
      stall_req_o = '{valid: 1'b1, is_trap: 1'b0, target: branch_tgt};
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch PC register, boot/run/flush sequencing and stall-time redirect latch
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CORE_RESET_PC,
  parameter int          XLEN     = CORE_XLEN
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  pc_gen_unit_if.slave bus
);

  pcg_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  pcg_redirect_t pending_q;
  logic          fetch_valid_q;
  logic          flush_q;

  logic            run_redirect_d;
  logic [XLEN-1:0] run_next_pc_d;
  pcg_redirect_t   pending_d;

  pc_next_sel u_next_sel (
    .pc_i           (pc_q),
    .branch_taken_i (bus.branch_taken_in),
    .target_addr_i  (bus.target_addr_in),
    .trap_taken_i   (bus.trap_taken_in),
    .trap_vec_i     (bus.trap_vec_in),
    .mret_i         (bus.mret_in),
    .epc_i          (bus.epc_in),
    .pending_i      (pending_q),
    .misaligned_o   (bus.misaligned_instr_out),
    .run_redirect_o (run_redirect_d),
    .run_next_pc_o  (run_next_pc_d),
    .stall_req_o    (pending_d)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= PCG_BOOT;
      pc_q          <= RESET_PC;
      pending_q     <= '0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      case (state_q)
        PCG_BOOT: begin
          state_q       <= PCG_RUN;
          fetch_valid_q <= 1'b1;
          flush_q       <= 1'b0;
          if (bus.trap_taken_in) begin
            pending_q <= '{valid: 1'b1, is_trap: 1'b1, target: bus.trap_vec_in};
          end
        end
        PCG_RUN: begin
          if (bus.stall_in) begin
            pending_q <= pending_d;
          end else if (run_redirect_d) begin
            pc_q          <= run_next_pc_d;
            pending_q     <= '0;
            state_q       <= PCG_FLUSH;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b1;
          end else begin
            pc_q <= run_next_pc_d;
          end
        end
        PCG_FLUSH: begin
          // Only a trap survives the squash; branch/mret came from killed instructions
          if (bus.trap_taken_in) begin
            pc_q <= bus.trap_vec_in;
          end else begin
            state_q       <= PCG_RUN;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
          end
        end
        default: begin
          state_q       <= PCG_BOOT;
          fetch_valid_q <= 1'b0;
          flush_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out          = pc_q;
  assign bus.i_addr_out      = pc_q;
  assign bus.pc_plus_4_out   = pc_q + XLEN'(4);
  assign bus.fetch_valid_out = fetch_valid_q;
  assign bus.flush_out       = flush_q;

endmodule
